msrh_l2_req_arbiter: RTL
========================

MSRH_L2_REQ_ARBITER -- requirements
Module: msrh_l2_req_arbiter

Interface
REQ-001 Parameter DATA_W, default msrh_pkg::ICACHE_DATA_W, request/response data width.
REQ-002 Parameter TAG_W, default msrh_pkg::L2_CMD_TAG_W, requester tag width.
REQ-003 Parameter ADDR_W, default riscv_pkg::PADDR_W, physical address width.
REQ-004 Parameter MAX_OUTSTANDING, default 4, per-port read limit.
REQ-005 i_clk  input  1  clock, rising edge.
REQ-006 w_msrh_reset_n  input  1  reset, asynchronous, active-low.
REQ-007 i_p0_req_valid/cmd(mem_cmd_t)/addr(ADDR_W)/tag(TAG_W)/data(DATA_W)/byte_en(DATA_W/8)  input  port-0 (ICache) request.
REQ-008 o_p0_req_ready  output  1  port-0 request accepted.
REQ-009 o_p0_resp_valid(1)/tag(TAG_W)/data(DATA_W)  output; i_p0_resp_ready  input  1  port-0 response.
REQ-010 i_p1_* / o_p1_*  same set as REQ-007..009  port-1 (data-side) requester.
REQ-011 o_l2_req_valid/cmd/addr/tag(TAG_W+1)/data/byte_en  output; i_l2_req_ready  input  request to L2.
REQ-012 i_l2_resp_valid(1)/tag(TAG_W+1)/data(DATA_W)  input; o_l2_resp_ready  output  1  L2 response.

Function
REQ-013 Request path: single output register slot; o_l2_req_* driven only from the slot.
REQ-014 Slot free when empty or draining this cycle (o_l2_req_valid & i_l2_req_ready).
REQ-015 Port eligible: req_valid and not (cmd==M_XRD and outstanding count==MAX_OUTSTANDING).
REQ-016 Grant: at most one port per cycle, only if slot free; one eligible -> that port; both -> port named by rr pointer.
REQ-017 o_pN_req_ready = grant to port N, combinational; never asserted for an ineligible port.
REQ-018 On grant: slot loads request; slot tag = {port id, requester tag}, port id in MSB; rr pointer moves to the other port.
REQ-019 Latency: accepted request appears on o_l2_req_valid the next cycle; back-to-back throughput one per cycle when L2 ready held high.
REQ-020 Slot contents stable while o_l2_req_valid & !i_l2_req_ready.
REQ-021 Outstanding counter per port (width clog2(MAX_OUTSTANDING+1)): +1 on granted M_XRD, -1 on response fire to that port; both same cycle -> unchanged.
REQ-022 Writes (M_XWR) generate no response and do not touch counters.
REQ-023 Response path: combinational route by i_l2_resp_tag MSB; o_pN_resp_valid = i_l2_resp_valid & MSB==N; o_pN_resp_tag = i_l2_resp_tag[TAG_W-1:0]; data broadcast.
REQ-024 o_l2_resp_ready = i_pN_resp_ready of port selected by MSB.
REQ-025 Response with zero counter on target port: counter saturates at 0, flag error (sim assertion).
REQ-026 Count never exceeds MAX_OUTSTANDING; full port blocks reads only, writes still arbitrate.

Reset
REQ-027 Reset: slot empty, o_l2_req_valid=0, counters=0, rr pointer=port 0; o_pN_req_ready=0 while asserted.
REQ-028 Reset mid-transaction discards slot and counters; in-flight L2 responses after reset are routed but not counted (REQ-025 applies).

Structure
REQ-029 L2_ARB_PORTS=2 and l2_arb_req_t (cmd, addr, tag, data, byte_en) in msrh_pkg.
REQ-030 Grant logic in sub-module msrh_rr_arbiter2 (2-way round robin, pointer register inside).

Verification
REQ-031 P0 and P1 reads valid same cycle after reset, L2 ready=1 -> P0 granted cycle 0, P1 cycle 1, L2 tags {0,t0},{1,t1}.
REQ-032 P0 issues 5 reads, no responses, MAX=4 -> 4 accepted, 5th stalls until one response to P0 fires, accepted next cycle.
REQ-033 L2 ready=0 for 3 cycles with slot full -> o_l2_req_* unchanged, both o_pN_req_ready=0, releases in order.
REQ-034 L2 response tag {1,0x5}, P1 resp_ready=0 -> o_l2_resp_ready=0, P0 resp_valid=0; P1 ready=1 -> fire, P1 counter -1.
REQ-035 Same-cycle P0 read grant and P0 response fire with count=2 -> count stays 2.
REQ-036 Reset asserted with slot full and count=3 -> o_l2_req_valid=0 and count=0 immediately, P0 priority after release.

Source files
------------

// File: rtl/msrh_pkg.sv
// msrh_pkg: memory-side widths, commands and the L2 arbiter request bundle
package msrh_pkg;

    localparam int ICACHE_DATA_W = 64;
    localparam int L2_CMD_TAG_W  = 4;
    localparam int L2_ARB_PORTS  = 2;

    typedef enum logic [1:0] {
        M_XRD = 2'd0,
        M_XWR = 2'd1
    } mem_cmd_t;

    // One request as seen by L2: tag carries the source port in its MSB
    typedef struct packed {
        mem_cmd_t                        cmd;
        logic [riscv_pkg::PADDR_W-1:0]   addr;
        logic [L2_CMD_TAG_W:0]           tag;
        logic [ICACHE_DATA_W-1:0]        data;
        logic [ICACHE_DATA_W/8-1:0]      byte_en;
    } l2_arb_req_t;

endpackage

// File: rtl/riscv_pkg.sv
// riscv_pkg: architectural widths shared across the core
package riscv_pkg;

    localparam int PADDR_W = 32;

endpackage

// File: rtl/msrh_l2_req_arbiter_rr.sv
// msrh_rr_arbiter2: two-way round-robin grant with an internal priority pointer
module msrh_rr_arbiter2 (
    input  logic       i_clk,
    input  logic       w_msrh_reset_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    logic r_ptr;
    logic w_ptr_next;

    // Pointer register: names the port favoured when both request
    always_ff @(posedge i_clk or negedge w_msrh_reset_n) begin
        if (!w_msrh_reset_n) r_ptr <= 1'b0;
        else                 r_ptr <= w_ptr_next;
    end

    // After any grant the other port becomes favoured
    always_comb begin
        w_ptr_next = (|o_grant) ? o_grant[0] : r_ptr;
    end

    // Grant: a lone requester wins outright, a tie goes to the pointer
    always_comb begin
        o_grant = 2'b00;
        if (i_en) o_grant = (i_req == 2'b11) ? (r_ptr ? 2'b10 : 2'b01) : i_req;
    end

endmodule

// File: rtl/msrh_l2_req_arbiter.sv
// msrh_l2_req_arbiter: merges ICache and data-side requests into one L2 port
module msrh_l2_req_arbiter
    import msrh_pkg::*;
#(
    parameter int DATA_W          = msrh_pkg::ICACHE_DATA_W,
    parameter int TAG_W           = msrh_pkg::L2_CMD_TAG_W,
    parameter int ADDR_W          = riscv_pkg::PADDR_W,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                i_clk,
    input  logic                w_msrh_reset_n,

    input  logic                i_p0_req_valid,
    input  mem_cmd_t            i_p0_req_cmd,
    input  logic [ADDR_W-1:0]   i_p0_req_addr,
    input  logic [TAG_W-1:0]    i_p0_req_tag,
    input  logic [DATA_W-1:0]   i_p0_req_data,
    input  logic [DATA_W/8-1:0] i_p0_req_byte_en,
    output logic                o_p0_req_ready,
    output logic                o_p0_resp_valid,
    output logic [TAG_W-1:0]    o_p0_resp_tag,
    output logic [DATA_W-1:0]   o_p0_resp_data,
    input  logic                i_p0_resp_ready,

    input  logic                i_p1_req_valid,
    input  mem_cmd_t            i_p1_req_cmd,
    input  logic [ADDR_W-1:0]   i_p1_req_addr,
    input  logic [TAG_W-1:0]    i_p1_req_tag,
    input  logic [DATA_W-1:0]   i_p1_req_data,
    input  logic [DATA_W/8-1:0] i_p1_req_byte_en,
    output logic                o_p1_req_ready,
    output logic                o_p1_resp_valid,
    output logic [TAG_W-1:0]    o_p1_resp_tag,
    output logic [DATA_W-1:0]   o_p1_resp_data,
    input  logic                i_p1_resp_ready,

    output logic                o_l2_req_valid,
    output mem_cmd_t            o_l2_req_cmd,
    output logic [ADDR_W-1:0]   o_l2_req_addr,
    output logic [TAG_W:0]      o_l2_req_tag,
    output logic [DATA_W-1:0]   o_l2_req_data,
    output logic [DATA_W/8-1:0] o_l2_req_byte_en,
    input  logic                i_l2_req_ready,

    input  logic                i_l2_resp_valid,
    input  logic [TAG_W:0]      i_l2_resp_tag,
    input  logic [DATA_W-1:0]   i_l2_resp_data,
    output logic                o_l2_resp_ready
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [L2_ARB_PORTS-1:0]            w_req_valid;
    logic [L2_ARB_PORTS-1:0]            w_is_rd;
    logic [L2_ARB_PORTS-1:0]            w_eligible;
    logic [L2_ARB_PORTS-1:0]            w_grant;
    logic [L2_ARB_PORTS-1:0]            w_resp_fire;
    logic [L2_ARB_PORTS-1:0]            w_inc;
    logic [L2_ARB_PORTS-1:0]            w_dec;
    logic [L2_ARB_PORTS-1:0][CNT_W-1:0] r_cnt;
    logic                               w_slot_free;
    logic                               w_resp_port;

    logic                r_slot_valid;
    mem_cmd_t            r_slot_cmd;
    logic [ADDR_W-1:0]   r_slot_addr;
    logic [TAG_W:0]      r_slot_tag;
    logic [DATA_W-1:0]   r_slot_data;
    logic [DATA_W/8-1:0] r_slot_byte_en;

    assign w_req_valid = {i_p1_req_valid, i_p0_req_valid};
    assign w_is_rd     = {i_p1_req_cmd == M_XRD, i_p0_req_cmd == M_XRD};

    // The slot can take a new request when empty or being drained this cycle
    assign w_slot_free = ~r_slot_valid | i_l2_req_ready;

    // A full port only loses reads; writes never return and are never counted
    for (genvar g = 0; g < L2_ARB_PORTS; g++) begin : g_elig
        assign w_eligible[g] = w_req_valid[g] & ~(w_is_rd[g] & (r_cnt[g] == CNT_W'(MAX_OUTSTANDING)));
    end

    msrh_rr_arbiter2 u_rr (
        .i_clk          (i_clk),
        .w_msrh_reset_n (w_msrh_reset_n),
        .i_en           (w_slot_free & w_msrh_reset_n),
        .i_req          (w_eligible),
        .o_grant        (w_grant)
    );

    assign o_p0_req_ready = w_grant[0];
    assign o_p1_req_ready = w_grant[1];

    // Slot occupancy: filled by a grant, emptied by an L2 handshake
    always_ff @(posedge i_clk or negedge w_msrh_reset_n) begin
        if (!w_msrh_reset_n)  r_slot_valid <= 1'b0;
        else if (|w_grant)    r_slot_valid <= 1'b1;
        else if (i_l2_req_ready) r_slot_valid <= 1'b0;
    end

    // Slot payload: only written on a grant, so it holds while L2 stalls
    always_ff @(posedge i_clk) begin
        if (|w_grant) begin
            r_slot_cmd     <= w_grant[1] ? i_p1_req_cmd     : i_p0_req_cmd;
            r_slot_addr    <= w_grant[1] ? i_p1_req_addr    : i_p0_req_addr;
            r_slot_tag     <= {w_grant[1], w_grant[1] ? i_p1_req_tag : i_p0_req_tag};
            r_slot_data    <= w_grant[1] ? i_p1_req_data    : i_p0_req_data;
            r_slot_byte_en <= w_grant[1] ? i_p1_req_byte_en : i_p0_req_byte_en;
        end
    end

    assign o_l2_req_valid   = r_slot_valid;
    assign o_l2_req_cmd     = r_slot_cmd;
    assign o_l2_req_addr    = r_slot_addr;
    assign o_l2_req_tag     = r_slot_tag;
    assign o_l2_req_data    = r_slot_data;
    assign o_l2_req_byte_en = r_slot_byte_en;

    // Responses are steered purely by the port bit stored in the tag MSB
    assign w_resp_port     = i_l2_resp_tag[TAG_W];
    assign o_p0_resp_valid = i_l2_resp_valid & ~w_resp_port;
    assign o_p1_resp_valid = i_l2_resp_valid &  w_resp_port;
    assign o_p0_resp_tag   = i_l2_resp_tag[TAG_W-1:0];
    assign o_p1_resp_tag   = i_l2_resp_tag[TAG_W-1:0];
    assign o_p0_resp_data  = i_l2_resp_data;
    assign o_p1_resp_data  = i_l2_resp_data;
    assign o_l2_resp_ready = w_resp_port ? i_p1_resp_ready : i_p0_resp_ready;
    assign w_resp_fire     = {o_p1_resp_valid & i_p1_resp_ready, o_p0_resp_valid & i_p0_resp_ready};

    // A stray response on an idle port must not wrap the counter below zero
    for (genvar g = 0; g < L2_ARB_PORTS; g++) begin : g_cnt_ctl
        assign w_inc[g] = w_grant[g] & w_is_rd[g];
        assign w_dec[g] = w_resp_fire[g] & (r_cnt[g] != '0);
        a_no_stray_resp: assert property (@(posedge i_clk) disable iff (!w_msrh_reset_n)
            !(w_resp_fire[g] && r_cnt[g] == '0));
        a_cnt_bound: assert property (@(posedge i_clk) disable iff (!w_msrh_reset_n)
            r_cnt[g] <= CNT_W'(MAX_OUTSTANDING));
    end

    // Outstanding read counters: issue and return in the same cycle cancel out
    always_ff @(posedge i_clk or negedge w_msrh_reset_n) begin
        if (!w_msrh_reset_n) begin
            r_cnt <= '0;
        end else begin
            for (int p = 0; p < L2_ARB_PORTS; p++) begin
                if (w_inc[p] & ~w_dec[p])      r_cnt[p] <= r_cnt[p] + 1'b1;
                else if (~w_inc[p] & w_dec[p]) r_cnt[p] <= r_cnt[p] - 1'b1;
            end
        end
    end

endmodule
